alu_md_unit: RTL and testbench



---
 rtl/alu_md_if.sv | 29 ++
 rtl/alu_md_unit.sv | 176 +++++++++++++++++
 tb/tb_alu_md_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_md_if.sv
// Request/response bundle for alu_md_unit.
// The master drives the decoded op and operands. The slave returns the result strobe and status.
`timescale 1ns/1ps
interface alu_md_if #(parameter int XLEN = 32);
    logic            valid_in;
    logic            ready_out;
    logic            opb5;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            funct7b0;
    logic [1:0]      ALUOp;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            valid_out;
    logic            busy;

    modport master (
        output valid_in, opb5, funct3, funct7b5, funct7b0, ALUOp, src_a, src_b, flush,
        input  ready_out, result, zero, valid_out, busy
    );

    modport slave (
        input  valid_in, opb5, funct3, funct7b5, funct7b0, ALUOp, src_a, src_b, flush,
        output ready_out, result, zero, valid_out, busy
    );
endinterface

// File: rtl/alu_md_unit.sv
// Integer ALU with an optional iterative M-extension unit.
// Base ops complete in one cycle. Multiply and divide work on operand magnitudes and resolve one bit per cycle.
`timescale 1ns/1ps
module alu_md_unit #(
    parameter int XLEN  = 32,
    parameter int MD_EN = 1
) (
    input logic     clk,
    input logic     rst_n,
    alu_md_if.slave bus
);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state;
    logic [SW-1:0]     cnt;
    logic [2:0]        mop;
    logic              neg_q, neg_r;
    logic [XLEN-1:0]   mcand, divisor, quo, rem;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   result_q;
    logic              zero_q, valid_q, busy_q;

    logic              rdy, accept, is_m, special;
    logic              a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   alu_res, spec_res, mag_a, mag_b;
    logic [SW-1:0]     shamt;

    assign rdy           = (state == IDLE) || (state == DONE);
    assign accept        = bus.valid_in && rdy && !bus.flush;
    assign bus.ready_out = rdy;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.valid_out = valid_q;
    assign bus.busy      = busy_q;

    always_comb begin
        is_m    = (MD_EN != 0) && (bus.ALUOp == 2'b10) && bus.opb5 && bus.funct7b0;
        shamt   = bus.src_b[SW-1:0];
        alu_res = '0;
        case (bus.ALUOp)
            2'b00: alu_res = bus.src_a + bus.src_b;
            2'b01: alu_res = bus.src_a - bus.src_b;
            default: begin
                case (bus.funct3)
                    3'b000: alu_res = (bus.funct7b5 && bus.opb5) ? bus.src_a - bus.src_b
                                                                 : bus.src_a + bus.src_b;
                    3'b001: alu_res = bus.src_a << shamt;
                    3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
                    3'b011: alu_res = {{(XLEN-1){1'b0}}, bus.src_a < bus.src_b};
                    3'b100: alu_res = bus.src_a ^ bus.src_b;
                    3'b101: alu_res = bus.funct7b5 ? XLEN'($signed(bus.src_a) >>> shamt)
                                                   : bus.src_a >> shamt;
                    3'b110: alu_res = bus.src_a | bus.src_b;
                    default: alu_res = bus.src_a & bus.src_b;
                endcase
            end
        endcase
    end

    // Signedness per M op; divide-by-zero and INT_MIN/-1 bypass the iteration.
    always_comb begin
        if (!bus.funct3[2]) begin
            a_sgn = (bus.funct3 != 3'b011);
            b_sgn = !bus.funct3[1];
        end else begin
            a_sgn = !bus.funct3[0];
            b_sgn = !bus.funct3[0];
        end
        a_neg    = a_sgn && bus.src_a[XLEN-1];
        b_neg    = b_sgn && bus.src_b[XLEN-1];
        mag_a    = a_neg ? -bus.src_a : bus.src_a;
        mag_b    = b_neg ? -bus.src_b : bus.src_b;
        div_zero = (bus.src_b == '0);
        div_ovf  = a_sgn && (bus.src_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.src_b == '1);
        special  = bus.funct3[2] && (div_zero || div_ovf);
        if (div_zero)
            spec_res = bus.funct3[1] ? bus.src_a : '1;
        else
            spec_res = bus.funct3[1] ? '0 : bus.src_a;
    end

    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] prod_nx, prod_fin;
    logic [XLEN-1:0]   rem_nx, quo_nx, mul_out, div_out;
    logic              div_ge;

    always_comb begin
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_nx  = {mul_sum, prod[XLEN-1:1]};
        prod_fin = neg_q ? -prod_nx : prod_nx;
        mul_out  = (mop[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
        div_sh   = {rem, quo[XLEN-1]};
        div_diff = div_sh - {1'b0, divisor};
        div_ge   = !div_diff[XLEN];
        rem_nx   = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
        quo_nx   = {quo[XLEN-2:0], div_ge};
        div_out  = mop[1] ? (neg_r ? -rem_nx : rem_nx) : (neg_q ? -quo_nx : quo_nx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mop      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            mcand    <= '0;
            divisor  <= '0;
            quo      <= '0;
            rem      <= '0;
            prod     <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else if (bus.flush) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (accept && is_m && special) begin
                        result_q <= spec_res;
                        zero_q   <= (spec_res == '0);
                        valid_q  <= 1'b1;
                        state    <= DONE;
                    end else if (accept && is_m) begin
                        mop     <= bus.funct3;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        mcand   <= mag_a;
                        prod    <= {{XLEN{1'b0}}, mag_b};
                        quo     <= mag_a;
                        rem     <= '0;
                        divisor <= mag_b;
                        state   <= bus.funct3[2] ? DIV : MUL;
                    end else if (accept) begin
                        result_q <= alu_res;
                        zero_q   <= (alu_res == '0);
                        valid_q  <= 1'b1;
                    end
                end
                MUL: begin
                    prod <= prod_nx;
                    cnt  <= cnt + SW'(1);
                    if (cnt == SW'(XLEN-1)) begin
                        result_q <= mul_out;
                        zero_q   <= (mul_out == '0);
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: begin
                    quo <= quo_nx;
                    rem <= rem_nx;
                    cnt <= cnt + SW'(1);
                    if (cnt == SW'(XLEN-1)) begin
                        result_q <= div_out;
                        zero_q   <= (div_out == '0);
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= DONE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_md_unit.sv
// Directed bench for alu_md_unit: base ops, M ops, flush and reset.
// A second instance is built with the M extension disabled.
`timescale 1ns/1ps
module tb_alu_md_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_md_if #(.XLEN(32)) bus ();
    alu_md_if #(.XLEN(32)) bus0 ();

    alu_md_unit #(.XLEN(32), .MD_EN(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_md_unit #(.XLEN(32), .MD_EN(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one op at a negedge, then scrambles the inputs once it has been taken.
    task automatic applyStimulus(input logic [1:0] alu, input logic [2:0] f3, input logic f7b5,
                                 input logic f7b0, input logic opb5, input logic [31:0] a,
                                 input logic [31:0] b, output int lat, output int busyCnt,
                                 output logic [31:0] res);
        bus.ALUOp    = alu;
        bus.funct3   = f3;
        bus.funct7b5 = f7b5;
        bus.funct7b0 = f7b0;
        bus.opb5     = opb5;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.valid_in = 1'b1;
        lat          = 0;
        busyCnt      = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                bus.valid_in = 1'b0;
                bus.src_a    = $urandom;
                bus.src_b    = $urandom;
                bus.funct3   = 3'($urandom);
            end
            if (bus.busy) busyCnt++;
        end while (!bus.valid_out && lat < 100);
        res = bus.result;
    endtask

    int          lat, busyCnt, strobes;
    logic [31:0] res;

    initial begin
        bus.valid_in = 0; bus.flush = 0; bus.opb5 = 0; bus.funct3 = 0; bus.funct7b5 = 0;
        bus.funct7b0 = 0; bus.ALUOp = 0; bus.src_a = 0; bus.src_b = 0;
        bus0.valid_in = 0; bus0.flush = 0; bus0.opb5 = 0; bus0.funct3 = 0; bus0.funct7b5 = 0;
        bus0.funct7b0 = 0; bus0.ALUOp = 0; bus0.src_a = 0; bus0.src_b = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_result", bus.result, 0);
        checkOutput("rst_zero", bus.zero, 1);
        checkOutput("rst_valid", bus.valid_out, 0);
        checkOutput("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready", bus.ready_out, 1);

        bus.ALUOp = 2'b00; bus.src_a = 5; bus.src_b = 7; bus.valid_in = 1;
        @(negedge clk);
        checkOutput("add_valid", bus.valid_out, 1);
        checkOutput("add_result", bus.result, 12);
        bus.ALUOp = 2'b01;
        @(negedge clk);
        checkOutput("sub_valid", bus.valid_out, 1);
        checkOutput("sub_result", bus.result, 32'hFFFF_FFFE);
        bus.valid_in = 0;
        @(negedge clk);
        checkOutput("idle_valid", bus.valid_out, 0);
        checkOutput("hold_result", bus.result, 32'hFFFF_FFFE);
        checkOutput("hold_zero", bus.zero, 0);

        applyStimulus(2'b10, 3'b101, 1, 0, 1, 32'h8000_0000, 31, lat, busyCnt, res);
        checkOutput("sra", res, 32'hFFFF_FFFF);
        checkOutput("sra_lat", lat, 1);
        applyStimulus(2'b10, 3'b101, 0, 0, 1, 32'h8000_0000, 31, lat, busyCnt, res);
        checkOutput("srl", res, 1);
        applyStimulus(2'b10, 3'b011, 0, 0, 1, 1, 32'hFFFF_FFFF, lat, busyCnt, res);
        checkOutput("sltu", res, 1);
        applyStimulus(2'b10, 3'b010, 0, 0, 1, 1, 32'hFFFF_FFFF, lat, busyCnt, res);
        checkOutput("slt", res, 0);
        checkOutput("slt_zero", bus.zero, 1);
        applyStimulus(2'b10, 3'b000, 1, 0, 1, 10, 3, lat, busyCnt, res);
        checkOutput("f3_sub", res, 7);
        applyStimulus(2'b10, 3'b000, 1, 0, 0, 10, 3, lat, busyCnt, res);
        checkOutput("f3_addi", res, 13);
        applyStimulus(2'b10, 3'b001, 0, 0, 1, 1, 36, lat, busyCnt, res);
        checkOutput("sll_mask", res, 16);
        applyStimulus(2'b10, 3'b100, 0, 0, 1, 32'hF0F0, 32'hFF00, lat, busyCnt, res);
        checkOutput("xor", res, 32'h0FF0);
        applyStimulus(2'b10, 3'b111, 0, 0, 1, 32'hF0F0, 32'hFF00, lat, busyCnt, res);
        checkOutput("and", res, 32'hF000);
        applyStimulus(2'b10, 3'b110, 0, 0, 1, 32'hF0F0, 32'hFF00, lat, busyCnt, res);
        checkOutput("or", res, 32'hFFF0);

        applyStimulus(2'b10, 3'b011, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busyCnt, res);
        checkOutput("mulhu", res, 32'hFFFF_FFFE);
        checkOutput("mulhu_lat", lat, 33);
        checkOutput("mulhu_busy", busyCnt, 32);
        @(negedge clk);
        checkOutput("mulhu_strobe_once", bus.valid_out, 0);
        applyStimulus(2'b10, 3'b000, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busyCnt, res);
        checkOutput("mul", res, 1);
        applyStimulus(2'b10, 3'b001, 0, 1, 1, 32'h8000_0000, 2, lat, busyCnt, res);
        checkOutput("mulh_neg", res, 32'hFFFF_FFFF);
        applyStimulus(2'b10, 3'b001, 0, 1, 1, 32'h4000_0000, 4, lat, busyCnt, res);
        checkOutput("mulh_pos", res, 1);
        applyStimulus(2'b10, 3'b010, 0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busyCnt, res);
        checkOutput("mulhsu", res, 32'hFFFF_FFFF);
        applyStimulus(2'b10, 3'b100, 0, 1, 1, 32'hFFFF_FFF9, 2, lat, busyCnt, res);
        checkOutput("div_neg", res, 32'hFFFF_FFFD);
        checkOutput("div_lat", lat, 33);
        applyStimulus(2'b10, 3'b110, 0, 1, 1, 32'hFFFF_FFF9, 2, lat, busyCnt, res);
        checkOutput("rem_neg", res, 32'hFFFF_FFFF);
        applyStimulus(2'b10, 3'b101, 0, 1, 1, 7, 0, lat, busyCnt, res);
        checkOutput("divu_by0", res, 32'hFFFF_FFFF);
        checkOutput("divu_by0_lat", lat, 1);
        applyStimulus(2'b10, 3'b110, 0, 1, 1, 7, 0, lat, busyCnt, res);
        checkOutput("rem_by0", res, 7);
        applyStimulus(2'b10, 3'b110, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, lat, busyCnt, res);
        checkOutput("rem_ovf", res, 0);
        checkOutput("rem_ovf_lat", lat, 1);
        checkOutput("rem_ovf_zero", bus.zero, 1);
        applyStimulus(2'b10, 3'b100, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, lat, busyCnt, res);
        checkOutput("div_ovf", res, 32'h8000_0000);
        applyStimulus(2'b10, 3'b111, 0, 1, 1, 100, 7, lat, busyCnt, res);
        checkOutput("remu", res, 2);
        applyStimulus(2'b10, 3'b101, 0, 1, 1, 32'hFFFF_FFFF, 1, lat, busyCnt, res);
        checkOutput("divu_big", res, 32'hFFFF_FFFF);
        applyStimulus(2'b10, 3'b101, 0, 1, 1, 100, 7, lat, busyCnt, res);
        checkOutput("divu", res, 14);
        applyStimulus(2'b00, 3'b000, 0, 0, 0, 2, 2, lat, busyCnt, res);
        checkOutput("done_accept", res, 4);
        checkOutput("done_accept_lat", lat, 1);

        // Abort a divide part-way through; the result must keep the add's value.
        bus.ALUOp = 2'b10; bus.opb5 = 1; bus.funct7b0 = 1; bus.funct3 = 3'b100;
        bus.src_a = 100; bus.src_b = 7; bus.valid_in = 1;
        @(negedge clk);
        bus.valid_in = 0;
        repeat (9) @(negedge clk);
        checkOutput("flush_pre_busy", bus.busy, 1);
        bus.flush = 1;
        @(negedge clk);
        bus.flush = 0;
        checkOutput("flush_ready", bus.ready_out, 1);
        checkOutput("flush_busy", bus.busy, 0);
        checkOutput("flush_result_hold", bus.result, 4);
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.valid_out) strobes++;
            @(negedge clk);
        end
        checkOutput("flush_no_valid", strobes, 0);
        applyStimulus(2'b00, 3'b000, 0, 0, 0, 20, 22, lat, busyCnt, res);
        checkOutput("post_flush_add", res, 42);
        checkOutput("post_flush_lat", lat, 1);

        // Reset in the middle of a multiply.
        bus.ALUOp = 2'b10; bus.opb5 = 1; bus.funct7b0 = 1; bus.funct3 = 3'b000;
        bus.src_a = 3; bus.src_b = 5; bus.valid_in = 1;
        @(negedge clk);
        bus.valid_in = 0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_result", bus.result, 0);
        checkOutput("midrst_zero", bus.zero, 1);
        checkOutput("midrst_valid", bus.valid_out, 0);
        checkOutput("midrst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.valid_out) strobes++;
        end
        checkOutput("midrst_no_valid", strobes, 0);
        checkOutput("midrst_ready", bus.ready_out, 1);

        bus0.ALUOp = 2'b10; bus0.opb5 = 1; bus0.funct7b0 = 1; bus0.funct7b5 = 0;
        bus0.funct3 = 3'b000; bus0.src_a = 3; bus0.src_b = 4; bus0.valid_in = 1;
        @(negedge clk);
        bus0.valid_in = 0;
        checkOutput("nomd_valid", bus0.valid_out, 1);
        checkOutput("nomd_add", bus0.result, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
